// File: rtl/evm_multi_party_core.sv
// evm_multi_party_core
//   Parametrised voting core. An officer unlocks the machine, and each voter then
//   gets one ballot. Per-voter duplicates are blocked by a bitmap. Tallies and the
//   total saturate. A result phase registers the winner index and a tie flag.
//
//   Optional feature: define EVM_TIMEOUT_EN to close an unanswered ballot after
//   TIMEOUT_CYC cycles. The voter is not marked, so the same ID may vote again.
//
// Ports
//   clk, reset             rising-edge clock; asynchronous active-low reset
//   mode                   1 = voting, 0 = result
//   officer_id             unlock ID, checked in IDLE
//   voter_id/voter_valid   voter ID and its one-cycle qualifier
//   push                   party buttons, bit i = party i
//   show_result            result request (mode = 0)
//   reset_id/system_reset  authorised clear-all, honoured in RESULT only
//   status_led             machine unlocked (READY or BALLOT)
//   ballot_open            BALLOT state
//   vote_accepted          pulse: vote counted
//   vote_rejected          pulse: voter refused (or ballot timed out)
//   vote_count             flattened tallies, party i at [i*CNT_W +: CNT_W]
//   total_voting           accepted vote count
//   winner/winner_valid    winning index, valid in RESULT
//   tie                    max tally shared (RESULT only)
module evm_multi_party_core #(
  parameter int unsigned       N_PARTIES   = 4,
  parameter int unsigned       ID_W        = 5,
  parameter int unsigned       CNT_W       = 6,
  parameter int unsigned       TOTAL_W     = 8,
  parameter logic [ID_W-1:0]   OFFICER_ID  = 5'b11111,
  parameter logic [ID_W-1:0]   RESET_ID    = 5'b11110,
  parameter int unsigned       TIMEOUT_CYC = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             mode,
  input  logic [ID_W-1:0]                  officer_id,
  input  logic [ID_W-1:0]                  voter_id,
  input  logic                             voter_valid,
  input  logic [N_PARTIES-1:0]             push,
  input  logic                             show_result,
  input  logic [ID_W-1:0]                  reset_id,
  input  logic                             system_reset,
  output logic                             status_led,
  output logic                             ballot_open,
  output logic                             vote_accepted,
  output logic                             vote_rejected,
  output logic [N_PARTIES*CNT_W-1:0]       vote_count,
  output logic [TOTAL_W-1:0]               total_voting,
  output logic [$clog2(N_PARTIES)-1:0]     winner,
  output logic                             winner_valid,
  output logic                             tie
);

  localparam int unsigned WIN_W = $clog2(N_PARTIES);
  localparam int unsigned N_IDS = 2**ID_W;
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TOTAL_W-1:0] TOTAL_ONE = {{(TOTAL_W-1){1'b0}}, 1'b1};

  if (N_PARTIES < 2 || N_PARTIES > 16 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("evm_multi_party_core: N_PARTIES must be 2..16 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, READY, BALLOT, RESULT} state_t;

  state_t                              state_q, state_d;
  logic [N_PARTIES-1:0][CNT_W-1:0]     tally_q, tally_d;
  logic [TOTAL_W-1:0]                  total_q, total_d;
  logic [N_IDS-1:0]                    bitmap_q, bitmap_d;
  logic [ID_W-1:0]                     id_q, id_d;
  logic                                acc_q, acc_d;
  logic                                rej_q, rej_d;
  logic                                status_q, status_d;
  logic                                ballot_q, ballot_d;
  logic [WIN_W-1:0]                    winner_q, winner_d;
  logic                                wvalid_q, wvalid_d;
  logic                                tie_q, tie_d;

  logic [N_PARTIES-1:0] push_clean;
  logic                 push_one_hot;
  logic [WIN_W-1:0]     push_idx;
  logic [WIN_W-1:0]     best_idx;
  logic [CNT_W-1:0]     best_cnt;
  logic [4:0]           max_hits;
  logic                 tie_now;
  logic                 id_ok;

`ifdef EVM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            to_expired;
  assign to_expired = (to_q == TO_W'(TIMEOUT_CYC - 1));
`endif

  // case compares with 4-state identity in simulation, so X/Z buttons read as 0.
  always_comb begin
    push_clean = '0;
    for (int unsigned i = 0; i < N_PARTIES; i++) begin
      case (push[i])
        1'b1:    push_clean[i] = 1'b1;
        default: push_clean[i] = 1'b0;
      endcase
    end
  end

  assign push_one_hot = $onehot(push_clean);

  always_comb begin
    push_idx = '0;
    for (int unsigned i = 0; i < N_PARTIES; i++) begin
      if (push_clean[i]) push_idx = WIN_W'(i);
    end
  end

  // Strict '>' keeps the lowest index on equal tallies.
  always_comb begin
    best_idx = '0;
    best_cnt = tally_q[0];
    for (int unsigned i = 1; i < N_PARTIES; i++) begin
      if (tally_q[i] > best_cnt) begin
        best_cnt = tally_q[i];
        best_idx = WIN_W'(i);
      end
    end
    max_hits = '0;
    for (int unsigned i = 0; i < N_PARTIES; i++) begin
      if (tally_q[i] == best_cnt) max_hits = max_hits + 5'd1;
    end
    tie_now = (max_hits >= 5'd2);
  end

  assign id_ok = !bitmap_q[voter_id] && (voter_id != OFFICER_ID) && (voter_id != RESET_ID);

  always_comb begin
    state_d  = state_q;
    tally_d  = tally_q;
    total_d  = total_q;
    bitmap_d = bitmap_q;
    id_d     = id_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    acc_d    = 1'b0;
    rej_d    = 1'b0;
`ifdef EVM_TIMEOUT_EN
    to_d     = (state_q == BALLOT) ? to_q + TO_W'(1) : '0;
`endif

    case (state_q)
      IDLE: begin
        if (mode && officer_id == OFFICER_ID) begin
          state_d = READY;
        end else if (!mode && show_result) begin
          state_d  = RESULT;
          winner_d = best_idx;
          tie_d    = tie_now;
        end
      end
      READY: begin
        if (!mode) begin
          state_d = IDLE;
        end else if (voter_valid) begin
          if (id_ok) begin
            state_d = BALLOT;
            id_d    = voter_id;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      BALLOT: begin
        if (!mode) begin
          state_d = IDLE;
        end else if (push_one_hot) begin
          if (tally_q[push_idx] != '1) tally_d[push_idx] = tally_q[push_idx] + CNT_ONE;
          if (total_q != '1) total_d = total_q + TOTAL_ONE;
          bitmap_d[id_q] = 1'b1;
          acc_d          = 1'b1;
          state_d        = READY;
        end
`ifdef EVM_TIMEOUT_EN
        else if (to_expired) begin
          rej_d   = 1'b1;
          state_d = READY;
        end
`endif
      end
      RESULT: begin
        if (system_reset && reset_id == RESET_ID) begin
          tally_d  = '0;
          total_d  = '0;
          bitmap_d = '0;
          state_d  = IDLE;
        end else if (mode) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != RESULT) tie_d = 1'b0;
    wvalid_d = (state_d == RESULT);
    status_d = (state_d == READY) || (state_d == BALLOT);
    ballot_d = (state_d == BALLOT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      tally_q  <= '0;
      total_q  <= '0;
      bitmap_q <= '0;
      id_q     <= '0;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
      status_q <= 1'b0;
      ballot_q <= 1'b0;
      winner_q <= '0;
      wvalid_q <= 1'b0;
      tie_q    <= 1'b0;
`ifdef EVM_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tally_q  <= tally_d;
      total_q  <= total_d;
      bitmap_q <= bitmap_d;
      id_q     <= id_d;
      acc_q    <= acc_d;
      rej_q    <= rej_d;
      status_q <= status_d;
      ballot_q <= ballot_d;
      winner_q <= winner_d;
      wvalid_q <= wvalid_d;
      tie_q    <= tie_d;
`ifdef EVM_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  assign status_led    = status_q;
  assign ballot_open   = ballot_q;
  assign vote_accepted = acc_q;
  assign vote_rejected = rej_q;
  assign vote_count    = tally_q;
  assign total_voting  = total_q;
  assign winner        = winner_q;
  assign winner_valid  = wvalid_q;
  assign tie           = tie_q;

endmodule
